// File: rtl/vector_compare_exec.sv
// vector_compare_exec: two-stage, multi-lane compare/subtract unit with valid/ready handshakes on both sides.
// Define STICKY_MISMATCH_EN to build the sticky vector-mismatch flag; otherwise mismatch_sticky is tied low.
module vector_compare_exec #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] op_a,
  input  logic [LANES*WIDTH-1:0] op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       lane_zero,
  output logic [LANES-1:0]       lane_borrow,
  output logic [LANES-1:0]       lane_neg,
  output logic [LANES-1:0]       lane_ovf,
  output logic                   all_zero,
  output logic                   any_zero,
  input  logic                   sticky_clr,
  output logic                   mismatch_sticky
);
  localparam int VW = LANES * WIDTH;

  logic             s1_valid_r;
  logic [VW-1:0]    s1_a_r;
  logic [VW-1:0]    s1_b_r;
  logic [1:0]       s1_mode_r;
  logic             s1_load_s;
  logic             s2_load_s;
  logic             pop_s;
  logic [VW-1:0]    res_s;
  logic [LANES-1:0] zero_s;
  logic [LANES-1:0] borrow_s;
  logic [LANES-1:0] neg_s;
  logic [LANES-1:0] ovf_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH:0]   ext_s;

  // S1 can take a beat whenever it is empty or its contents move into S2 on this edge
  assign in_ready  = !s1_valid_r || !out_valid || out_ready;
  assign s1_load_s = in_valid && in_ready;
  assign s2_load_s = s1_valid_r && (!out_valid || out_ready);
  assign pop_s     = out_valid && out_ready;

  // Stage 1: operand and mode capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_mode_r  <= 2'd0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= op_a;
      s1_b_r     <= op_b;
      s1_mode_r  <= mode;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Per-lane subtract with a widened borrow bit, flags, and the mode-selected lane result
  always_comb begin
    res_s    = '0;
    zero_s   = '0;
    borrow_s = '0;
    neg_s    = '0;
    ovf_s    = '0;
    a_s      = '0;
    b_s      = '0;
    d_s      = '0;
    r_s      = '0;
    ext_s    = '0;
    for (int i = 0; i < LANES; i++) begin
      a_s         = s1_a_r[i*WIDTH +: WIDTH];
      b_s         = s1_b_r[i*WIDTH +: WIDTH];
      ext_s       = {1'b0, a_s} - {1'b0, b_s};
      d_s         = ext_s[WIDTH-1:0];
      borrow_s[i] = ext_s[WIDTH];
      neg_s[i]    = d_s[WIDTH-1];
      ovf_s[i]    = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (d_s[WIDTH-1] != a_s[WIDTH-1]);
      zero_s[i]   = (d_s == '0);
      case (s1_mode_r)
        2'd0:    r_s = d_s;
        2'd1:    r_s = {{(WIDTH-1){1'b0}}, ext_s[WIDTH]};
        2'd2:    r_s = {{(WIDTH-1){1'b0}}, d_s[WIDTH-1] ^ ovf_s[i]};
        2'd3:    r_s = ext_s[WIDTH] ? (b_s - a_s) : d_s;
        default: r_s = d_s;
      endcase
      res_s[i*WIDTH +: WIDTH] = r_s;
    end
  end

  // Stage 2: registered result and flags; holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      lane_zero   <= '0;
      lane_borrow <= '0;
      lane_neg    <= '0;
      lane_ovf    <= '0;
      all_zero    <= 1'b0;
      any_zero    <= 1'b0;
    end else if (s2_load_s) begin
      out_valid   <= 1'b1;
      result      <= res_s;
      lane_zero   <= zero_s;
      lane_borrow <= borrow_s;
      lane_neg    <= neg_s;
      lane_ovf    <= ovf_s;
      all_zero    <= &zero_s;
      any_zero    <= |zero_s;
    end else if (pop_s) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef STICKY_MISMATCH_EN
  logic sticky_r;

  // Sticky mismatch: a departing unequal beat sets it, and setting beats a coincident clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 1'b0;
    end else if (pop_s && !all_zero) begin
      sticky_r <= 1'b1;
    end else if (sticky_clr) begin
      sticky_r <= 1'b0;
    end
  end

  assign mismatch_sticky = sticky_r;
`else
  logic sticky_unused_s;

  assign sticky_unused_s = sticky_clr;
  assign mismatch_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_vector_compare_exec.sv
// Scoreboard bench for vector_compare_exec: a monitor pushes model expectations on accept and pops/compares on
// each output handshake; reference model works on plain integers. Honours STICKY_MISMATCH_EN if defined.
`timescale 1ns/1ps
module tb_vector_compare_exec;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int VW    = LANES * WIDTH;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH - 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             sticky_clr = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [VW-1:0]    op_a = '0;
  logic [VW-1:0]    op_b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [VW-1:0]    result;
  logic [LANES-1:0] lane_zero, lane_borrow, lane_neg, lane_ovf;
  logic             all_zero, any_zero, mismatch_sticky;

  typedef struct {
    logic [VW-1:0]    res;
    logic [LANES-1:0] z, br, ng, ov;
    logic             az, anz;
    int               cyc;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            pops = 0;
  int            run_len = 0;
  int            max_run = 0;
  bit            chk_lat = 1'b0;
  bit            rnd_ready = 1'b0;
  bit            exp_sticky = 1'b0;
  bit            hold_chk = 1'b0;
  bit            set_ev;
  logic [VW-1:0] held_res;
  logic [4*LANES+1:0] held_flags;

  vector_compare_exec #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .lane_zero(lane_zero), .lane_borrow(lane_borrow),
    .lane_neg(lane_neg), .lane_ovf(lane_ovf), .all_zero(all_zero), .any_zero(any_zero),
    .sticky_clr(sticky_clr), .mismatch_sticky(mismatch_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic straight from the lane rules
  function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m);
    exp_t e;
    int ai, bi, sa, sb, diff, d, r;
    e.res = '0; e.z = '0; e.br = '0; e.ng = '0; e.ov = '0; e.cyc = 0;
    for (int i = 0; i < LANES; i++) begin
      ai   = int'(a[i*WIDTH +: WIDTH]);
      bi   = int'(b[i*WIDTH +: WIDTH]);
      sa   = (ai >= HALF) ? ai - MOD : ai;
      sb   = (bi >= HALF) ? bi - MOD : bi;
      diff = ai - bi;
      d    = (diff < 0) ? diff + MOD : diff;
      e.z[i]  = (diff == 0);
      e.br[i] = (ai < bi);
      e.ng[i] = (d >= HALF);
      e.ov[i] = ((sa - sb) > HALF - 1) || ((sa - sb) < -HALF);
      case (m)
        2'd0:    r = d;
        2'd1:    r = (ai < bi) ? 1 : 0;
        2'd2:    r = (sa < sb) ? 1 : 0;
        default: r = (diff < 0) ? -diff : diff;
      endcase
      e.res[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
    e.az  = &e.z;
    e.anz = |e.z;
    return e;
  endfunction

  // Monitor: mid-cycle sampling of both handshakes, scoreboard push/pop, stall stability, sticky model
  initial begin
    forever begin
      @(negedge clk);
      check("sticky", mismatch_sticky, exp_sticky);
      if (rst) begin
        sb_q.delete();
        exp_sticky = 1'b0;
        hold_chk   = 1'b0;
        run_len    = 0;
      end else begin
        if (hold_chk) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_result", result, held_res);
          check("hold_flags", {lane_zero, lane_borrow, lane_neg, lane_ovf, all_zero, any_zero}, held_flags);
        end
        run_len = out_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        set_ev = 1'b0;
        if (out_valid && out_ready) begin
          pops++;
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got result %0h, want no beat (cycle %0d)", result, cyc);
          end else begin
            mon_e = sb_q.pop_front();
            check("result", result, mon_e.res);
            check("lane_flags", {lane_zero, lane_borrow, lane_neg, lane_ovf}, {mon_e.z, mon_e.br, mon_e.ng, mon_e.ov});
            check("all_any_zero", {all_zero, any_zero}, {mon_e.az, mon_e.anz});
            if (chk_lat) check("latency", cyc - mon_e.cyc, 2);
            set_ev = !mon_e.az;
          end
        end
`ifdef STICKY_MISMATCH_EN
        if (set_ev) exp_sticky = 1'b1;
        else if (sticky_clr) exp_sticky = 1'b0;
`endif
        hold_chk   = out_valid && !out_ready;
        held_res   = result;
        held_flags = {lane_zero, lane_borrow, lane_neg, lane_ovf, all_zero, any_zero};
        if (in_valid && in_ready) begin
          mon_e     = model(op_a, op_b, mode);
          mon_e.cyc = cyc;
          sb_q.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish by 500000ns");
    $fatal(1, "watchdog");
  end

  // Offer one beat from posedge+1 and return once it has been taken
  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m);
    int  n = 0;
    bit  done = 1'b0;
    op_a = a; op_b = b; mode = m; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else if (n > 200) begin
        done = 1'b1;
        tests++; fails++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want accept", n);
      end
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d beats pending, want 0", sb_q.size());
    end
  endtask

  task automatic rand_ops(output logic [VW-1:0] ra, output logic [VW-1:0] rb);
    int av, bv, sel;
    for (int i = 0; i < LANES; i++) begin
      av  = $urandom_range(0, MOD - 1);
      bv  = $urandom_range(0, MOD - 1);
      sel = $urandom_range(0, 7);
      if (sel == 0) bv = av;
      else if (sel == 1) av = HALF;
      else if (sel == 2) bv = MOD - 1;
      else if (sel == 3) bv = HALF - 1;
      ra[i*WIDTH +: WIDTH] = av[WIDTH-1:0];
      rb[i*WIDTH +: WIDTH] = bv[WIDTH-1:0];
    end
    if ($urandom_range(0, 9) == 0) rb = ra;
  endtask

  logic [VW-1:0] ba[3], bb[3], ra, rb;
  logic [1:0]    bm[3];
  int            acc, p0;
  bit            took;
  logic          want_sticky;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_flags", {lane_zero, lane_borrow, lane_neg, lane_ovf, all_zero, any_zero}, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed arithmetic corner cases
    out_ready = 1'b1;
    send({8'h00, 8'h80, 8'h05, 8'h10}, {8'h00, 8'h01, 8'h07, 8'h10}, 2'd0);
    send(32'h0000_00FF, 32'h0000_0001, 2'd2);
    send(32'h0000_00FF, 32'h0000_0001, 2'd1);
    send(32'h0000_0003, 32'h0000_0009, 2'd3);
    send(32'h7F80_0903, 32'h807F_0309, 2'd3);
    send(32'h7F80_0001, 32'h807F_0100, 2'd2);
    drain();

    // Back-pressure: three beats offered into a stalled pipe
    for (int k = 0; k < 3; k++) begin
      rand_ops(ba[k], bb[k]);
      bm[k] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b0;
    acc = 0;
    op_a = ba[0]; op_b = bb[0]; mode = bm[0]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        if (acc < 3) begin op_a = ba[acc]; op_b = bb[acc]; mode = bm[acc]; end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_accepts", acc, 2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(ba[2], bb[2], bm[2]);
    drain();

    // Full-rate stream with latency checking
    max_run = 0;
    chk_lat = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rand_ops(ra, rb);
      send(ra, rb, 2'($urandom_range(0, 3)));
    end
    drain();
    chk_lat = 1'b0;
    check("stream_run", max_run, 16);

    // Reset with both stages full
    out_ready = 1'b0;
    rand_ops(ra, rb); send(ra, rb, 2'd0);
    rand_ops(ra, rb); send(ra, rb, 2'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_result", result, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    p0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_beats", pops - p0, 0);

    // Sticky mismatch: equal, unequal, equal, then clear
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    rand_ops(ra, rb);
    send(ra, ra, 2'd0);
    send(ra, ra ^ 32'h0000_0001, 2'd0);
    send(ra, ra, 2'd1);
    drain();
`ifdef STICKY_MISMATCH_EN
    want_sticky = 1'b1;
`else
    want_sticky = 1'b0;
`endif
    @(negedge clk);
    check("sticky_after_mismatch", mismatch_sticky, want_sticky);
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_after_clear", mismatch_sticky, 1'b0);
    @(posedge clk); #1;

    // Randomised traffic with random back-pressure and clear pulses
    rnd_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rand_ops(ra, rb);
      sticky_clr = ($urandom_range(0, 7) == 0);
      send(ra, rb, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk); #1;
      end
    end
    sticky_clr = 1'b0;
    rnd_ready = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
